// File: rtl/axi_compare_mismatch_monitor.sv
// rtl/axi_compare_mismatch_monitor.sv - records AXI comparison mismatches: counters, sticky flags, first capture, busy watchdog, irq
module axi_compare_mismatch_monitor #(
    parameter int AxiIdWidth    = 0,
    parameter int CntWidth      = 16,
    parameter int TsWidth       = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic                                      clear_i,
    input  logic [2**AxiIdWidth-1:0]                  aw_mismatch_i,
    input  logic                                      w_mismatch_i,
    input  logic [2**AxiIdWidth-1:0]                  b_mismatch_i,
    input  logic [2**AxiIdWidth-1:0]                  ar_mismatch_i,
    input  logic [2**AxiIdWidth-1:0]                  r_mismatch_i,
    input  logic                                      busy_i,
    output logic [5*CntWidth-1:0]                     cnt_o,
    output logic [4:0]                                sticky_o,
    output logic                                      first_valid_o,
    output logic [2:0]                                first_chan_o,
    output logic [((AxiIdWidth > 0) ? AxiIdWidth : 1)-1:0] first_id_o,
    output logic [TsWidth-1:0]                        first_ts_o,
    output logic                                      timeout_o,
    output logic                                      irq_o
);
    localparam int IdN  = 2**AxiIdWidth;
    localparam int IdW  = (AxiIdWidth > 0) ? AxiIdWidth : 1;
    localparam bit WdEn = (TimeoutCycles > 0);
    localparam int WdW  = WdEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [WdW-1:0] WdMax = WdW'(TimeoutCycles);

    logic [4:0]          ev;
    logic [CntWidth-1:0] cnt_q [5];
    logic [2:0]          cap_chan;
    logic [IdW-1:0]      cap_id;
    logic [TsWidth-1:0]  ts_q;
    logic [WdW-1:0]      wd_q;
    logic [WdW-1:0]      wd_d;

    function automatic logic [IdW-1:0] lowest_id(input logic [IdN-1:0] v);
        lowest_id = '0;
        for (int i = IdN - 1; i >= 0; i--) begin
            if (v[i]) lowest_id = IdW'(i);
        end
    endfunction

    // A channel counts once per cycle no matter how many ID strobes are set.
    assign ev = {|r_mismatch_i, |ar_mismatch_i, |b_mismatch_i, w_mismatch_i, |aw_mismatch_i};

    always_comb begin
        cap_chan = 3'd0;
        cap_id   = '0;
        if (ev[0]) begin
            cap_chan = 3'd0;
            cap_id   = lowest_id(aw_mismatch_i);
        end else if (ev[1]) begin
            cap_chan = 3'd1;
        end else if (ev[2]) begin
            cap_chan = 3'd2;
            cap_id   = lowest_id(b_mismatch_i);
        end else if (ev[3]) begin
            cap_chan = 3'd3;
            cap_id   = lowest_id(ar_mismatch_i);
        end else if (ev[4]) begin
            cap_chan = 3'd4;
            cap_id   = lowest_id(r_mismatch_i);
        end
    end

    always_comb begin
        wd_d = '0;
        if (WdEn && busy_i) begin
            wd_d = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
            sticky_o      <= '0;
            first_valid_o <= 1'b0;
            first_chan_o  <= '0;
            first_id_o    <= '0;
            first_ts_o    <= '0;
            ts_q          <= '0;
            wd_q          <= '0;
            timeout_o     <= 1'b0;
            irq_o         <= 1'b0;
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (ev[i] && (cnt_q[i] != {CntWidth{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
            sticky_o <= sticky_o | ev;
            if (!first_valid_o && (|ev)) begin
                first_valid_o <= 1'b1;
                first_chan_o  <= cap_chan;
                first_id_o    <= cap_id;
                first_ts_o    <= ts_q;
            end
            ts_q      <= ts_q + 1'b1;
            wd_q      <= wd_d;
            timeout_o <= timeout_o | (WdEn && (wd_d == WdMax));
            // Built from the registered flags, so irq trails them by one cycle.
            irq_o     <= first_valid_o | timeout_o;
        end
    end

    for (genvar g = 0; g < 5; g++) begin : g_cnt
        assign cnt_o[g*CntWidth +: CntWidth] = cnt_q[g];
    end
endmodule

// File: tb/tb_axi_compare_mismatch_monitor.sv
// tb/tb_axi_compare_mismatch_monitor.sv - randomized bench for axi_compare_mismatch_monitor against a reference model
module tb_axi_compare_mismatch_monitor;
    localparam int IdW  = 2;
    localparam int CW   = 4;
    localparam int TW   = 8;
    localparam int TO   = 8;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          rst, clr, w, busy;
    logic [3:0]    aw, b, ar, r;
    logic [5*CW-1:0] cnt;
    logic [4:0]    sticky;
    logic          fv, to, irq;
    logic [2:0]    fchan;
    logic [IdW-1:0] fid;
    logic [TW-1:0] fts;

    int n_checks = 0;
    int n_errors = 0;

    int       m_cnt [5];
    bit [4:0] m_sticky;
    bit       m_fv, m_to, m_irq;
    int       m_chan, m_id, m_fts, m_ts, m_run;

    axi_compare_mismatch_monitor #(
        .AxiIdWidth(IdW), .CntWidth(CW), .TsWidth(TW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .aw_mismatch_i(aw), .w_mismatch_i(w), .b_mismatch_i(b),
        .ar_mismatch_i(ar), .r_mismatch_i(r), .busy_i(busy),
        .cnt_o(cnt), .sticky_o(sticky), .first_valid_o(fv),
        .first_chan_o(fchan), .first_id_o(fid), .first_ts_o(fts),
        .timeout_o(to), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_step();
        bit [4:0] evs;
        logic [3:0] vec [5];
        bit irq_n;
        if (rst || clr) begin
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            m_sticky = '0; m_fv = 0; m_to = 0; m_irq = 0;
            m_chan = 0; m_id = 0; m_fts = 0; m_ts = 0; m_run = 0;
            return;
        end
        vec[0] = aw; vec[1] = {3'b000, w}; vec[2] = b; vec[3] = ar; vec[4] = r;
        irq_n = m_fv || m_to;
        for (int i = 0; i < 5; i++) begin
            evs[i] = (vec[i] != 0);
            if (evs[i]) begin
                m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                m_sticky[i] = 1'b1;
            end
        end
        if (!m_fv) begin
            for (int i = 0; i < 5; i++) begin
                if (evs[i]) begin
                    m_fv = 1; m_chan = i; m_id = (i == 1) ? 0 : lowest(vec[i]); m_fts = m_ts;
                    break;
                end
            end
        end
        m_ts  = (m_ts + 1) % (1 << TW);
        m_run = busy ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
        if (m_run >= TO) m_to = 1;
        m_irq = irq_n;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 5; i++) check($sformatf("cnt%0d", i), 32'(cnt[i*CW +: CW]), 32'(m_cnt[i]));
        check("sticky", 32'(sticky), 32'(m_sticky));
        check("first_valid", 32'(fv), 32'(m_fv));
        check("first_chan", 32'(fchan), 32'(m_chan));
        check("first_id", 32'(fid), 32'(m_id));
        check("first_ts", 32'(fts), 32'(m_fts));
        check("timeout", 32'(to), 32'(m_to));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        aw = '0; w = 1'b0; b = '0; ar = '0; r = '0; busy = 1'b0; clr = 1'b0; rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (10) cycle();
        check("idle_first_ts", 32'(fts), 32'd0);
        check("idle_irq", 32'(irq), 32'd0);

        // single capture at timestamp 7
        clr = 1'b1; cycle(); clr = 1'b0;
        for (int k = 0; k < 300 && m_ts != 7; k++) cycle();
        r = 4'b0100; cycle(); r = '0;
        check("cap_cnt_r", 32'(cnt[4*CW +: CW]), 32'd1);
        check("cap_sticky", 32'(sticky), 32'b10000);
        check("cap_chan", 32'(fchan), 32'd4);
        check("cap_id", 32'(fid), 32'd2);
        check("cap_ts", 32'(fts), 32'd7);
        check("cap_irq_early", 32'(irq), 32'd0);
        cycle();
        check("cap_irq", 32'(irq), 32'd1);

        // simultaneous priority
        clr = 1'b1; cycle(); clr = 1'b0;
        b = 4'b1010; w = 1'b1; ar = 4'b0001; cycle(); idle_inputs();
        check("pri_chan", 32'(fchan), 32'd1);
        check("pri_id", 32'(fid), 32'd0);
        check("pri_cnt_w", 32'(cnt[1*CW +: CW]), 32'd1);
        check("pri_cnt_b", 32'(cnt[2*CW +: CW]), 32'd1);
        check("pri_cnt_ar", 32'(cnt[3*CW +: CW]), 32'd1);
        aw = 4'b0001; cycle(); aw = '0;
        check("pri_frozen_chan", 32'(fchan), 32'd1);

        // saturation
        aw = 4'b0001; repeat (20) cycle(); aw = '0;
        check("sat_cnt_aw", 32'(cnt[0 +: CW]), 32'd15);
        cycle();
        check("sat_hold", 32'(cnt[0 +: CW]), 32'd15);

        // clear collides with an event
        clr = 1'b1; aw = 4'b0001; cycle(); idle_inputs();
        check("clr_cnt", 32'(cnt), 32'd0);
        check("clr_sticky", 32'(sticky), 32'd0);
        check("clr_fv", 32'(fv), 32'd0);
        check("clr_irq", 32'(irq), 32'd0);

        // watchdog
        busy = 1'b1; repeat (7) cycle();
        busy = 1'b0; cycle();
        check("wd_after_short", 32'(to), 32'd0);
        busy = 1'b1; repeat (7) cycle();
        check("wd_7", 32'(to), 32'd0);
        cycle();
        check("wd_8", 32'(to), 32'd1);
        check("wd_irq_early", 32'(irq), 32'd0);
        busy = 1'b0; cycle();
        check("wd_irq", 32'(irq), 32'd1);

        // randomized traffic
        for (int k = 0; k < 700; k++) begin
            aw   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            w    = ($urandom_range(0, 7) == 0);
            b    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            ar   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            r    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            busy = ($urandom_range(0, 11) != 0);
            clr  = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 249) == 0);
            cycle();
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
